// File: rtl/mem_stage_lsu_if.sv
// Data-memory port bundle between the MEM-stage load/store unit (master)
// and the data memory (slave): registered request fields plus ack/read data.
interface mem_stage_lsu_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one req/ack access per load/store, pipeline freeze
// while outstanding, registered aligned/extended load data. Option: MISALIGN_TRAP_EN.
module mem_stage_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] st_data,
  input  logic        pipe_stall,
  output logic        stall_mem,
  output logic [31:0] ld_data,
  output logic        misalign,
  mem_stage_lsu_if.master dm
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] ld_q, ld_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        mis_q, mis_d;
  logic        access_s;
  logic        mis_s;

  // Size is funct3[1:0]: 00 byte, 01 half, anything else a full word.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (f3[1:0])
      2'b00:   return {4{sd[7:0]}};
      2'b01:   return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [31:0] rd);
    logic [7:0]  sh_b;
    logic [15:0] sh_h;
    sh_b = 8'(rd >> {off, 3'b000});
    sh_h = 16'(rd >> {off[1], 4'b0000});
    case (f3)
      3'b000:  return {{24{sh_b[7]}}, sh_b};
      3'b100:  return {24'h000000, sh_b};
      3'b001:  return {{16{sh_h[15]}}, sh_h};
      3'b101:  return {16'h0000, sh_h};
      default: return rd;
    endcase
  endfunction

  assign access_s = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    mis_s = 1'b0;
    if (access_s) begin
      case (funct3[1:0])
        2'b00:   mis_s = 1'b0;
        2'b01:   mis_s = addr[0];
        default: mis_s = (addr[1:0] != 2'b00);
      endcase
    end else begin
      mis_s = 1'b0;
    end
  end
`else
  assign mis_s = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    ld_d      = ld_q;
    f3_d      = f3_q;
    off_d     = off_q;
    mis_d     = 1'b0;
    stall_mem = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_s && mis_s) begin
          mis_d = 1'b1;
        end else if (access_s) begin
          stall_mem = 1'b1;
          state_d   = BUSY;
          req_d     = 1'b1;
          we_d      = mem_write;
          addr_d    = {addr[31:2], 2'b00};
          wdata_d   = mem_write ? store_wdata(funct3, st_data) : wdata_q;
          wstrb_d   = mem_write ? store_wstrb(funct3, addr[1:0]) : 4'b0000;
          f3_d      = funct3;
          off_d     = addr[1:0];
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        stall_mem = 1'b1;
        if (dm.dm_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          ld_d    = we_q ? ld_q : load_extract(f3_q, off_q, dm.dm_rdata);
        end else begin
          state_d = BUSY;
        end
      end
      // DONE never reissues; it only waits for the pipeline to move on.
      DONE: begin
        if (pipe_stall) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      wstrb_q <= 4'b0000;
      ld_q    <= 32'h0000_0000;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      ld_q    <= ld_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      mis_q   <= mis_d;
    end
  end

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign dm.dm_wstrb = wstrb_q;
  assign ld_data     = ld_q;
  assign misalign    = mis_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized self-checking bench for mem_stage_lsu against a byte-lane reference model.
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, pipe_stall, stall_mem, misalign;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data, ld_data;

  int          n_vec = 0;
  int          n_err = 0;
  int          req_cnt = 0;
  logic        prev_req;
  logic [31:0] exp_ld;

  mem_stage_lsu_if dm_if();

  mem_stage_lsu dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .st_data(st_data), .pipe_stall(pipe_stall),
    .stall_mem(stall_mem), .ld_data(ld_data), .misalign(misalign), .dm(dm_if)
  );

  always #5 clk = ~clk;

  // Count distinct requests (rising edges of dm_req seen at clock edges).
  always @(posedge clk or posedge rst) begin
    if (rst) prev_req <= 1'b0;
    else begin
      if (dm_if.dm_req && !prev_req) req_cnt <= req_cnt + 1;
      prev_req <= dm_if.dm_req;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int lane_start(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = size_of(f3);
    return (int'(a % 4) / sz) * sz;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int sz, st;
    logic [31:0] v;
    sz = size_of(f3);
    st = lane_start(f3, a);
    v = 32'h0;
    for (int b = 0; b < sz; b++) v[8*b +: 8] = rd[8*(st+b) +: 8];
    if (f3[2] == 1'b0 && sz < 4 && v[8*sz-1])
      for (int b = sz; b < 4; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] a);
    int sz, st;
    logic [3:0] s;
    sz = size_of(f3);
    st = lane_start(f3, a);
    for (int b = 0; b < 4; b++) s[b] = (b >= st) && (b < st + sz);
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    int sz;
    logic [31:0] w;
    sz = size_of(f3);
    for (int b = 0; b < 4; b++) w[8*b +: 8] = sd[8*(b % sz) +: 8];
    return w;
  endfunction

  function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % size_of(f3)) != 0;
  endfunction

  // ---------------- one complete load/store, checked every cycle ----------------
  task automatic access(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd,
                        input int wait_c, input int dstall);
    int  cnt0;
    bit  trap;
`ifdef MISALIGN_TRAP_EN
    trap = model_misaligned(f3, a);
`else
    trap = 1'b0;
`endif
    cnt0 = req_cnt;
    mem_read = ld; mem_write = !ld; funct3 = f3; addr = a; st_data = sd;
    pipe_stall = 1'b0; dm_if.dm_ack = 1'b0;
    #1;
    if (trap) begin
      n_vec++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL trap_stall: got %b expected 0", stall_mem); end
      @(posedge clk); #2;
      n_vec++; if (misalign !== 1'b1) begin n_err++; $display("FAIL trap_pulse: got %b expected 1", misalign); end
      n_vec++; if (dm_if.dm_req !== 1'b0) begin n_err++; $display("FAIL trap_req: got %b expected 0", dm_if.dm_req); end
      mem_read = 1'b0; mem_write = 1'b0;
      @(posedge clk); #2;
      n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL trap_pulse_end: got %b expected 0", misalign); end
      n_vec++; if (ld_data !== exp_ld) begin n_err++; $display("FAIL trap_ld: got %h expected %h", ld_data, exp_ld); end
      n_vec++; if (req_cnt != cnt0) begin n_err++; $display("FAIL trap_reqcnt: got %0d expected %0d", req_cnt - cnt0, 0); end
      return;
    end
    n_vec++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL c0_stall: got %b expected 1", stall_mem); end
    n_vec++; if (dm_if.dm_req !== 1'b0) begin n_err++; $display("FAIL c0_req: got %b expected 0", dm_if.dm_req); end
    @(posedge clk); #2;
    for (int w = 0; w <= wait_c; w++) begin
      dm_if.dm_ack   = (w == wait_c);
      dm_if.dm_rdata = (w == wait_c) ? rd : $urandom;
      #1;
      n_vec++; if (dm_if.dm_req !== 1'b1) begin n_err++; $display("FAIL busy_req: got %b expected 1", dm_if.dm_req); end
      n_vec++; if (stall_mem !== 1'b1) begin n_err++; $display("FAIL busy_stall: got %b expected 1", stall_mem); end
      n_vec++; if (dm_if.dm_addr !== {a[31:2], 2'b00}) begin n_err++; $display("FAIL busy_addr: got %h expected %h", dm_if.dm_addr, {a[31:2], 2'b00}); end
      n_vec++; if (dm_if.dm_we !== !ld) begin n_err++; $display("FAIL busy_we: got %b expected %b", dm_if.dm_we, !ld); end
      n_vec++; if (dm_if.dm_wstrb !== (ld ? 4'b0000 : model_strb(f3, a))) begin n_err++; $display("FAIL busy_wstrb: got %b expected %b", dm_if.dm_wstrb, ld ? 4'b0000 : model_strb(f3, a)); end
      if (!ld) begin
        n_vec++; if (dm_if.dm_wdata !== model_wdata(f3, sd)) begin n_err++; $display("FAIL busy_wdata: got %h expected %h", dm_if.dm_wdata, model_wdata(f3, sd)); end
      end
      @(posedge clk); #2;
    end
    if (ld) exp_ld = model_load(f3, a, rd);
    for (int d = 0; d <= dstall; d++) begin
      pipe_stall     = (d < dstall);
      dm_if.dm_ack   = 1'($urandom_range(0, 1));
      dm_if.dm_rdata = $urandom;
      #1;
      n_vec++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL done_stall: got %b expected 0", stall_mem); end
      n_vec++; if (dm_if.dm_req !== 1'b0) begin n_err++; $display("FAIL done_req: got %b expected 0", dm_if.dm_req); end
      n_vec++; if (ld_data !== exp_ld) begin n_err++; $display("FAIL done_ld: got %h expected %h", ld_data, exp_ld); end
      @(posedge clk); #2;
    end
    mem_read = 1'b0; mem_write = 1'b0; pipe_stall = 1'b0; dm_if.dm_ack = 1'b0;
    #1;
    n_vec++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL idle_stall: got %b expected 0", stall_mem); end
    n_vec++; if (dm_if.dm_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b expected 0", dm_if.dm_req); end
    n_vec++; if (ld_data !== exp_ld) begin n_err++; $display("FAIL idle_ld: got %h expected %h", ld_data, exp_ld); end
    n_vec++; if (req_cnt - cnt0 != 1) begin n_err++; $display("FAIL req_count: got %0d expected 1", req_cnt - cnt0); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = 32'h0;
    st_data = 32'h0; pipe_stall = 1'b0; dm_if.dm_ack = 1'b0; dm_if.dm_rdata = 32'h0;
    exp_ld = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    n_vec++; if (dm_if.dm_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b expected 0", dm_if.dm_req); end
    n_vec++; if (dm_if.dm_we !== 1'b0 || dm_if.dm_wstrb !== 4'b0000) begin n_err++; $display("FAIL rst_we_strb: got %b/%b expected 0/0000", dm_if.dm_we, dm_if.dm_wstrb); end
    n_vec++; if (dm_if.dm_addr !== 32'h0 || dm_if.dm_wdata !== 32'h0) begin n_err++; $display("FAIL rst_addr_wdata: got %h/%h expected 0/0", dm_if.dm_addr, dm_if.dm_wdata); end
    n_vec++; if (ld_data !== 32'h0 || misalign !== 1'b0 || stall_mem !== 1'b0) begin n_err++; $display("FAIL rst_misc: got ld=%h mis=%b stall=%b expected 0/0/0", ld_data, misalign, stall_mem); end
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_load_word();
    access(1'b1, 3'b010, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 0, 0);
  endtask

  task automatic test_load_ext();
    access(1'b1, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF0011, 0, 0);
    n_vec++; if (ld_data !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_const: got %h expected FFFFFF80", ld_data); end
    access(1'b1, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF0011, 0, 0);
    n_vec++; if (ld_data !== 32'h00000080) begin n_err++; $display("FAIL lbu_const: got %h expected 00000080", ld_data); end
    access(1'b1, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF0011, 1, 0);
    n_vec++; if (ld_data !== 32'hFFFF80FF) begin n_err++; $display("FAIL lh_const: got %h expected FFFF80FF", ld_data); end
  endtask

  task automatic test_store();
    access(1'b0, 3'b000, 32'h0000_0201, 32'h12345678, 32'h0, 0, 0);
    n_vec++; if (ld_data !== 32'hFFFF80FF) begin n_err++; $display("FAIL sb_ld_hold: got %h expected FFFF80FF", ld_data); end
    access(1'b0, 3'b001, 32'h0000_0302, 32'hCAFEBABE, 32'h0, 2, 1);
    access(1'b0, 3'b010, 32'h0000_0400, 32'hA5A55A5A, 32'h0, 0, 0);
  endtask

  task automatic test_wait_stall();
    access(1'b1, 3'b010, 32'h0000_0500, 32'h0, 32'h01234567, 3, 2);
  endtask

  task automatic test_reset_mid();
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0600;
    dm_if.dm_ack = 1'b0;
    @(posedge clk); #2;
    n_vec++; if (dm_if.dm_req !== 1'b1) begin n_err++; $display("FAIL rmid_req_up: got %b expected 1", dm_if.dm_req); end
    rst = 1'b1; mem_read = 1'b0;
    #1;
    n_vec++; if (dm_if.dm_req !== 1'b0) begin n_err++; $display("FAIL rmid_req_drop: got %b expected 0", dm_if.dm_req); end
    n_vec++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL rmid_stall: got %b expected 0", stall_mem); end
    @(posedge clk); #2;
    rst = 1'b0; exp_ld = 32'h0;
    dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'h13579BDF;
    @(posedge clk); #2;
    dm_if.dm_ack = 1'b0;
    n_vec++; if (ld_data !== 32'h0) begin n_err++; $display("FAIL rmid_ld: got %h expected 00000000", ld_data); end
    n_vec++; if (dm_if.dm_req !== 1'b0) begin n_err++; $display("FAIL rmid_req_after: got %b expected 0", dm_if.dm_req); end
  endtask

  task automatic test_misalign();
    access(1'b1, 3'b010, 32'h0000_0102, 32'h0, 32'hCAFEF00D, 0, 0);
    access(1'b1, 3'b101, 32'h0000_0103, 32'h0, 32'h89AB4321, 0, 0);
    access(1'b0, 3'b010, 32'h0000_0703, 32'h11223344, 32'h0, 1, 0);
  endtask

  task automatic test_random();
    logic [2:0] f3;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      access(1'($urandom_range(0, 1)), f3, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) begin
        addr = $urandom; funct3 = 3'($urandom_range(0, 7)); pipe_stall = 1'($urandom_range(0, 1));
        dm_if.dm_ack = 1'($urandom_range(0, 1)); dm_if.dm_rdata = $urandom;
        #1;
        n_vec++; if (stall_mem !== 1'b0 || dm_if.dm_req !== 1'b0) begin n_err++; $display("FAIL rnd_idle: got stall=%b req=%b expected 0/0", stall_mem, dm_if.dm_req); end
        @(posedge clk); #2;
        n_vec++; if (ld_data !== exp_ld) begin n_err++; $display("FAIL rnd_idle_ld: got %h expected %h", ld_data, exp_ld); end
        pipe_stall = 1'b0; dm_if.dm_ack = 1'b0;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      access(1'(i % 2), 3'(i % 3), 32'h0000_0800 + 32'(i), 32'hF0E1D2C3 + 32'(i),
             32'h8877_6655 ^ 32'(i), 0, 0);
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_store();
    test_wait_stall();
    test_reset_mid();
    test_misalign();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
